gardner_loop_ctrl: RTL and testbench

GARDNER_LOOP_CTRL -- requirements
Module: gardner_loop_ctrl

---
 rtl/gardner_pkg.sv | 41 ++++
 rtl/gardner_lock_det.sv | 64 ++++++
 rtl/gardner_loop_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_gardner_loop_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/gardner_pkg.sv
// Shared state encoding, window classes and default loop constants for the Gardner timing-loop controller.
// Pure declarations and one combinational helper; no latency, no flow control.
package gardner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_LOCKED  = 2'd3
  } gstate_e;

  typedef enum logic [1:0] {
    WIN_GOOD    = 2'd0,
    WIN_NEUTRAL = 2'd1,
    WIN_BAD     = 2'd2
  } wclass_e;

  localparam int WIN_LOG2_DEF    = 5;
  localparam int ACQ_SHIFT_DEF   = 4;
  localparam int MID_SHIFT_DEF   = 6;
  localparam int TRK_SHIFT_DEF   = 9;
  localparam int LOCK_THR_DEF    = 1024;
  localparam int UNLOCK_THR_DEF  = 3072;
  localparam int LOCK_CNT_DEF    = 4;
  localparam int LOSS_CNT_DEF    = 3;
  localparam int TIMEOUT_WIN_DEF = 64;
  localparam int SETTLE_CNT      = 2;

  // |x| in 15 bits; the one unrepresentable magnitude (-32768) saturates to 32767.
  function automatic logic [14:0] abs_sat(input logic signed [15:0] x);
    logic [15:0] u;
    u = x;
    if (!u[15])
      return u[14:0];
    else if (u[14:0] == 15'd0)
      return 15'h7FFF;
    else
      return ~u[14:0] + 15'd1;
  endfunction

endpackage

// File: rtl/gardner_lock_det.sv
// Symbol-edge detect plus windowed mean of |error|; avg and win_done register one cycle after the closing strobe.
// No backpressure: strobes arriving while clr_win_i is high are discarded.
module gardner_lock_det
  import gardner_pkg::*;
#(
  parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               clr_win_i,
  input  logic               clr_avg_i,
  input  logic               clk_out_i,
  input  logic signed [15:0] err_i,
  output logic [15:0]        avg_o,
  output logic               win_done_o
);

  localparam int AW = 15 + WIN_LOG2;

  logic                clk_out_q;
  logic                sym_stb;
  logic [WIN_LOG2-1:0] sym_cnt_q;
  logic [AW-1:0]       acc_q;
  logic [AW-1:0]       sum;
  logic [15:0]         avg_q;
  logic                win_done_q;

  assign sym_stb = clk_out_i & ~clk_out_q;
  assign sum     = acc_q + AW'(abs_sat(err_i));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_out_q  <= 1'b0;
      sym_cnt_q  <= '0;
      acc_q      <= '0;
      avg_q      <= '0;
      win_done_q <= 1'b0;
    end else begin
      clk_out_q  <= clk_out_i;
      win_done_q <= 1'b0;
      if (clr_avg_i)
        avg_q <= '0;
      if (clr_win_i) begin
        acc_q     <= '0;
        sym_cnt_q <= '0;
      end else if (sym_stb) begin
        // Last symbol of the window: publish the mean and restart.
        if (&sym_cnt_q) begin
          avg_q      <= 16'(sum >> WIN_LOG2);
          acc_q      <= '0;
          sym_cnt_q  <= '0;
          win_done_q <= 1'b1;
        end else begin
          acc_q     <= sum;
          sym_cnt_q <= sym_cnt_q + WIN_LOG2'(1);
        end
      end
    end
  end

  assign avg_o      = avg_q;
  assign win_done_o = win_done_q;

endmodule

// File: rtl/gardner_loop_ctrl.sv
// Gardner loop-bandwidth FSM (IDLE/ACQUIRE/SETTLE/LOCKED); state updates on win_done, GARDNER_SHIFT one cycle later.
// No backpressure; GARDNER_ACQ_TIMEOUT_EN adds the ACQUIRE timeout that pulses loop_rst.
module gardner_loop_ctrl
  import gardner_pkg::*;
#(
  parameter int WIN_LOG2    = WIN_LOG2_DEF,
  parameter int ACQ_SHIFT   = ACQ_SHIFT_DEF,
  parameter int MID_SHIFT   = MID_SHIFT_DEF,
  parameter int TRK_SHIFT   = TRK_SHIFT_DEF,
  parameter int LOCK_THR    = LOCK_THR_DEF,
  parameter int UNLOCK_THR  = UNLOCK_THR_DEF,
  parameter int LOCK_CNT    = LOCK_CNT_DEF,
  parameter int LOSS_CNT    = LOSS_CNT_DEF,
  parameter int TIMEOUT_WIN = TIMEOUT_WIN_DEF
) (
  input  logic               clk_32M768,
  input  logic               rst_32M768,
  input  logic               enable,
  input  logic               clk_out,
  input  logic signed [15:0] error_n,
  output logic [3:0]         GARDNER_SHIFT,
  output logic               locked,
  output logic [1:0]         state,
  output logic [15:0]        err_avg,
  output logic               loop_rst
);

  if (UNLOCK_THR <= LOCK_THR || TIMEOUT_WIN < 1 || TIMEOUT_WIN > 65535) begin : g_cfg_err
    $error("gardner_loop_ctrl: UNLOCK_THR must exceed LOCK_THR and TIMEOUT_WIN must be 1..65535");
  end

  gstate_e     state_q;
  logic [7:0]  good_cnt_q;
  logic [7:0]  bad_cnt_q;
  logic        locked_q;
  logic [3:0]  shift_q;
  logic        win_done;
  logic [15:0] avg;
  logic        clr_win;
  wclass_e     wcls;

  function automatic logic [3:0] shift_of(input gstate_e s);
    case (s)
      ST_SETTLE: return 4'(MID_SHIFT);
      ST_LOCKED: return 4'(TRK_SHIFT);
      default:   return 4'(ACQ_SHIFT);
    endcase
  endfunction

  always_comb begin
    wcls = WIN_NEUTRAL;
    if (avg < 16'(LOCK_THR))
      wcls = WIN_GOOD;
    else if (avg >= 16'(UNLOCK_THR))
      wcls = WIN_BAD;
  end

`ifdef GARDNER_ACQ_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        loop_rst_q;
  assign loop_rst = loop_rst_q;
`else
  assign loop_rst = 1'b0;
`endif

  // The window keeps running across state changes; only stop and timeout discard it.
  assign clr_win = ~enable | (state_q == ST_IDLE) | loop_rst;

  always_ff @(posedge clk_32M768 or negedge rst_32M768) begin
    if (!rst_32M768) begin
      state_q    <= ST_IDLE;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      locked_q   <= 1'b0;
      shift_q    <= 4'(ACQ_SHIFT);
`ifdef GARDNER_ACQ_TIMEOUT_EN
      to_cnt_q   <= '0;
      loop_rst_q <= 1'b0;
`endif
    end else begin
      shift_q <= shift_of(state_q);
`ifdef GARDNER_ACQ_TIMEOUT_EN
      loop_rst_q <= 1'b0;
`endif
      if (!enable) begin
        state_q    <= ST_IDLE;
        good_cnt_q <= '0;
        bad_cnt_q  <= '0;
        locked_q   <= 1'b0;
`ifdef GARDNER_ACQ_TIMEOUT_EN
        to_cnt_q   <= '0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q    <= ST_ACQUIRE;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
`ifdef GARDNER_ACQ_TIMEOUT_EN
            to_cnt_q   <= '0;
`endif
          end
          ST_ACQUIRE: begin
            if (win_done) begin
              if (wcls == WIN_GOOD && good_cnt_q == 8'(LOCK_CNT - 1)) begin
                state_q    <= ST_SETTLE;
                good_cnt_q <= '0;
`ifdef GARDNER_ACQ_TIMEOUT_EN
                to_cnt_q   <= '0;
`endif
              end else begin
                good_cnt_q <= (wcls == WIN_GOOD) ? good_cnt_q + 8'd1 : 8'd0;
`ifdef GARDNER_ACQ_TIMEOUT_EN
                if (to_cnt_q == 16'(TIMEOUT_WIN - 1)) begin
                  loop_rst_q <= 1'b1;
                  to_cnt_q   <= '0;
                  good_cnt_q <= '0;
                  bad_cnt_q  <= '0;
                end else begin
                  to_cnt_q <= to_cnt_q + 16'd1;
                end
`endif
              end
            end
          end
          ST_SETTLE: begin
            if (win_done) begin
              case (wcls)
                WIN_GOOD: begin
                  if (good_cnt_q == 8'(SETTLE_CNT - 1)) begin
                    state_q    <= ST_LOCKED;
                    locked_q   <= 1'b1;
                    good_cnt_q <= '0;
                  end else begin
                    good_cnt_q <= good_cnt_q + 8'd1;
                  end
                end
                WIN_BAD: begin
                  state_q    <= ST_ACQUIRE;
                  good_cnt_q <= '0;
                end
                default: good_cnt_q <= '0;
              endcase
            end
          end
          ST_LOCKED: begin
            if (win_done) begin
              if (wcls == WIN_BAD) begin
                if (bad_cnt_q == 8'(LOSS_CNT - 1)) begin
                  state_q   <= ST_ACQUIRE;
                  locked_q  <= 1'b0;
                  bad_cnt_q <= '0;
                end else begin
                  bad_cnt_q <= bad_cnt_q + 8'd1;
                end
              end else begin
                bad_cnt_q <= '0;
              end
            end
          end
        endcase
      end
    end
  end

  gardner_lock_det #(
    .WIN_LOG2(WIN_LOG2)
  ) u_lock_det (
    .clk_i     (clk_32M768),
    .rst_n_i   (rst_32M768),
    .clr_win_i (clr_win),
    .clr_avg_i (~enable),
    .clk_out_i (clk_out),
    .err_i     (error_n),
    .avg_o     (avg),
    .win_done_o(win_done)
  );

  assign state         = state_q;
  assign GARDNER_SHIFT = shift_q;
  assign locked        = locked_q;
  assign err_avg       = avg;

endmodule

// File: tb/tb_gardner_loop_ctrl.sv
// Directed scoreboard bench: each expected output change is queued with the symbol count at which it must appear.
module tb_gardner_loop_ctrl;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               enable = 1'b0;
  logic               clk_out = 1'b0;
  logic signed [15:0] error_n = '0;
  logic [3:0]         GARDNER_SHIFT;
  logic               locked;
  logic [1:0]         state;
  logic [15:0]        err_avg;
  logic               loop_rst;

  always #5 clk = ~clk;

  gardner_loop_ctrl dut (
    .clk_32M768   (clk),
    .rst_32M768   (rst_n),
    .enable       (enable),
    .clk_out      (clk_out),
    .error_n      (error_n),
    .GARDNER_SHIFT(GARDNER_SHIFT),
    .locked       (locked),
    .state        (state),
    .err_avg      (err_avg),
    .loop_rst     (loop_rst)
  );

  typedef struct {
    logic [23:0] v;
    int          sym;
  } exp_t;

  exp_t        q[$];
  exp_t        e_mon;
  int          n_chk = 0;
  int          n_pass = 0;
  int          sym_total = 0;
  int          n_evt = 0;
  bit          mon_en = 1'b0;
  logic [23:0] prev;
  logic [23:0] cur_v;

  function automatic logic [23:0] pk(input int st, input int lk, input int sh, input int av, input int lr);
    return {st[1:0], lk[0], sh[3:0], av[15:0], lr[0]};
  endfunction

  function automatic logic [23:0] obs();
    return {state, locked, GARDNER_SHIFT, err_avg, loop_rst};
  endfunction

  task automatic push(input int st, input int lk, input int sh, input int av, input int lr, input int sym);
    exp_t e;
    e.v   = pk(st, lk, sh, av, lr);
    e.sym = sym;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got st/lk/sh/avg/lr=%0d/%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d/%0d", name,
                  act[23:22], act[21], act[20:17], act[16:1], act[0], exp[23:22], exp[21], exp[20:17], exp[16:1], exp[0]);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  // Monitor: every change of the observed outputs consumes one queued expectation.
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      cur_v = obs();
      if (cur_v !== prev) begin
        prev = cur_v;
        n_evt++;
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_change: got %h at sym %0d required no change", cur_v, sym_total);
        end else begin
          e_mon = q.pop_front();
          check($sformatf("evt%0d_val", n_evt), cur_v, e_mon.v);
          check_int($sformatf("evt%0d_sym", n_evt), sym_total, e_mon.sym);
        end
      end
    end
  end

  // One symbol = clk_out high for 'half' cycles then low for 'half' cycles.
  task automatic run_syms(input int n, input int half, input int v, input bit alt);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      error_n = (alt && i[0]) ? 16'(-v) : 16'(v);
      clk_out = 1'b1;
      sym_total++;
      repeat (half) @(negedge clk);
      clk_out = 1'b0;
      repeat (half - 1) @(negedge clk);
    end
  endtask

  int b;

  initial begin
    // Reset with clk_out already high: no symbol may be counted from it.
    clk_out = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_vals", obs(), pk(0, 0, 4, 0, 0));
    rst_n = 1'b1;
    prev   = pk(0, 0, 4, 0, 0);
    mon_en = 1'b1;
    repeat (3) @(negedge clk);

    push(1, 0, 4, 0, 0, 0);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    clk_out = 1'b0;
    repeat (4) @(negedge clk);

    // Acquisition with constant +100, 32-cycle symbols.
    b = sym_total;
    push(1, 0, 4, 100, 0, b + 32);
    push(2, 0, 4, 100, 0, b + 128);
    push(2, 0, 6, 100, 0, b + 128);
    push(3, 1, 6, 100, 0, b + 192);
    push(3, 1, 9, 100, 0, b + 192);
    run_syms(192, 16, 100, 1'b0);

    // Full-scale negative error: saturated mean, lock lost on the third bad window.
    b = sym_total;
    push(3, 1, 9, 32767, 0, b + 32);
    push(1, 0, 9, 32767, 0, b + 96);
    push(1, 0, 4, 32767, 0, b + 96);
    run_syms(96, 4, -32768, 1'b0);

    // Neutral windows never leave ACQUIRE.
    b = sym_total;
    push(1, 0, 4, 2000, 0, b + 32);
    run_syms(192, 4, 2000, 1'b1);

    // Relock.
    b = sym_total;
    push(1, 0, 4, 100, 0, b + 32);
    push(2, 0, 4, 100, 0, b + 128);
    push(2, 0, 6, 100, 0, b + 128);
    push(3, 1, 6, 100, 0, b + 192);
    push(3, 1, 9, 100, 0, b + 192);
    run_syms(192, 4, 100, 1'b0);

    // In LOCKED, a neutral window restarts the bad-window count.
    b = sym_total;
    push(3, 1, 9, 32767, 0, b + 32);
    push(3, 1, 9, 2000, 0, b + 96);
    push(3, 1, 9, 32767, 0, b + 128);
    push(3, 1, 9, 2000, 0, b + 192);
    run_syms(64, 4, -32768, 1'b0);
    run_syms(32, 4, 2000, 1'b1);
    run_syms(64, 4, -32768, 1'b0);
    run_syms(160, 4, 2000, 1'b1);

    // Asynchronous reset mid-cycle while LOCKED.
    push(0, 0, 4, 0, 0, sym_total);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", obs(), pk(0, 0, 4, 0, 0));
    repeat (3) @(negedge clk);
    push(1, 0, 4, 0, 0, sym_total);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Reach SETTLE, then stop mid-window.
    b = sym_total;
    push(1, 0, 4, 100, 0, b + 32);
    push(2, 0, 4, 100, 0, b + 128);
    push(2, 0, 6, 100, 0, b + 128);
    run_syms(128, 4, 100, 1'b0);
    run_syms(10, 4, 100, 1'b0);
    push(0, 0, 6, 0, 0, sym_total);
    push(0, 0, 4, 0, 0, sym_total);
    @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #2 check_int("disable_next_cycle", int'(state), 0);
    repeat (6) @(negedge clk);
    b = sym_total;
    push(1, 0, 4, 0, 0, b);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    push(1, 0, 4, 300, 0, b + 32);
    run_syms(32, 4, 300, 1'b0);

    // Bad-error acquisition: timeout pulses (when built in) or nothing.
    push(0, 0, 4, 0, 0, sym_total);
    @(negedge clk);
    enable = 1'b0;
    repeat (4) @(negedge clk);
    b = sym_total;
    push(1, 0, 4, 0, 0, b);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    push(1, 0, 4, 5000, 0, b + 32);
`ifdef GARDNER_ACQ_TIMEOUT_EN
    for (int k = 1; k <= 2; k++) begin
      push(1, 0, 4, 5000, 1, b + k * 2048);
      push(1, 0, 4, 5000, 0, b + k * 2048);
    end
    run_syms(4096, 2, 5000, 1'b0);
`else
    run_syms(192, 2, 5000, 1'b0);
`endif

    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_int("sb_drain", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
